// File: rtl/cmat_pkg.sv
// Shared types and helpers for the sequential 2x2 complex matrix multiplier.
package cmat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NSTEPS = 8;

    // Flat element index of a 2x2 matrix stored row-major.
    function automatic logic [1:0] elem_idx(input logic row, input logic col);
        return {row, col};
    endfunction

endpackage

// File: rtl/mult_complex.sv
// Combinational signed complex multiplier: (a_re + j a_im) * (b_re + j b_im).
module mult_complex #(
    parameter int W = 16
) (
    input  logic signed [W-1:0]   a_re,
    input  logic signed [W-1:0]   a_im,
    input  logic signed [W-1:0]   b_re,
    input  logic signed [W-1:0]   b_im,
    output logic signed [2*W:0]   p_re,
    output logic signed [2*W:0]   p_im
);

    logic signed [2*W-1:0] rr;
    logic signed [2*W-1:0] ii;
    logic signed [2*W-1:0] ri;
    logic signed [2*W-1:0] ir;

    assign rr = (2*W)'(a_re) * (2*W)'(b_re);
    assign ii = (2*W)'(a_im) * (2*W)'(b_im);
    assign ri = (2*W)'(a_re) * (2*W)'(b_im);
    assign ir = (2*W)'(a_im) * (2*W)'(b_re);

    // One extra bit absorbs the sum/difference of two full-scale products.
    assign p_re = (2*W+1)'(rr) - (2*W+1)'(ii);
    assign p_im = (2*W+1)'(ri) + (2*W+1)'(ir);

endmodule

// File: rtl/cmat2_mult_seq.sv
// 2x2 complex matrix product C = A*B using one shared complex multiplier,
// stepping through the 8 partial products and accumulating into C.
module cmat2_mult_seq
    import cmat_pkg::*;
#(
    parameter  int W  = 16,
    localparam int CW = 2*W + 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*W-1:0]  a_re,
    input  logic [4*W-1:0]  a_im,
    input  logic [4*W-1:0]  b_re,
    input  logic [4*W-1:0]  b_im,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4*CW-1:0] c_re,
    output logic [4*CW-1:0] c_im,
    output logic            busy
);

    state_t state;
    logic [2:0] step;

    logic signed [W-1:0]  a_re_q [4];
    logic signed [W-1:0]  a_im_q [4];
    logic signed [W-1:0]  b_re_q [4];
    logic signed [W-1:0]  b_im_q [4];
    logic signed [CW-1:0] c_re_q [4];
    logic signed [CW-1:0] c_im_q [4];

    logic [1:0] a_sel;
    logic [1:0] b_sel;
    logic [1:0] c_sel;

    logic signed [2*W:0]  p_re;
    logic signed [2*W:0]  p_im;
    logic signed [CW-1:0] p_re_ext;
    logic signed [CW-1:0] p_im_ext;

    // Step bits map to i=step[2], j=step[1], l=step[0]: C[i][j] += A[i][l]*B[l][j].
    assign a_sel = elem_idx(step[2], step[0]);
    assign b_sel = elem_idx(step[0], step[1]);
    assign c_sel = elem_idx(step[2], step[1]);

    mult_complex #(
        .W(W)
    ) u_mult (
        .a_re(a_re_q[a_sel]),
        .a_im(a_im_q[a_sel]),
        .b_re(b_re_q[b_sel]),
        .b_im(b_im_q[b_sel]),
        .p_re(p_re),
        .p_im(p_im)
    );

    assign p_re_ext = {p_re[2*W], p_re};
    assign p_im_ext = {p_im[2*W], p_im};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int e = 0; e < 4; e++) begin
                a_re_q[e] <= '0;
                a_im_q[e] <= '0;
                b_re_q[e] <= '0;
                b_im_q[e] <= '0;
                c_re_q[e] <= '0;
                c_im_q[e] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int e = 0; e < 4; e++) begin
                            a_re_q[e] <= a_re[e*W +: W];
                            a_im_q[e] <= a_im[e*W +: W];
                            b_re_q[e] <= b_re[e*W +: W];
                            b_im_q[e] <= b_im[e*W +: W];
                        end
                        step     <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // l=0 starts a fresh element so stale results never leak in.
                    if (step[0]) begin
                        c_re_q[c_sel] <= c_re_q[c_sel] + p_re_ext;
                        c_im_q[c_sel] <= c_im_q[c_sel] + p_im_ext;
                    end else begin
                        c_re_q[c_sel] <= p_re_ext;
                        c_im_q[c_sel] <= p_im_ext;
                    end
                    if (step == 3'(NSTEPS - 1)) begin
                        step      <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    step      <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar e = 0; e < 4; e++) begin : g_pack
        assign c_re[e*CW +: CW] = c_re_q[e];
        assign c_im[e*CW +: CW] = c_im_q[e];
    end

endmodule

// File: tb/tb_cmat2_mult_seq.sv
// Randomized self-checking bench for cmat2_mult_seq against a plain-arithmetic
// complex matrix product model.
module tb_cmat2_mult_seq;

    localparam int W  = 16;
    localparam int CW = 2*W + 2;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4*W-1:0]  a_re;
    logic [4*W-1:0]  a_im;
    logic [4*W-1:0]  b_re;
    logic [4*W-1:0]  b_im;
    logic            out_valid;
    logic            out_ready;
    logic [4*CW-1:0] c_re;
    logic [4*CW-1:0] c_im;
    logic            busy;

    int vectors;
    int miscompares;
    int cyc;

    longint a_r [4];
    longint a_i [4];
    longint b_r [4];
    longint b_i [4];
    longint e_r [4];
    longint e_i [4];

    cmat2_mult_seq #(
        .W(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_re(a_re),
        .a_im(a_im),
        .b_re(b_re),
        .b_im(b_im),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c_re(c_re),
        .c_im(c_im),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint cRe(input int e);
        logic signed [CW-1:0] t;
        t = c_re[e*CW +: CW];
        return longint'(t);
    endfunction

    function automatic longint cIm(input int e);
        logic signed [CW-1:0] t;
        t = c_im[e*CW +: CW];
        return longint'(t);
    endfunction

    // Textbook product: C[i][j] = sum over l of A[i][l]*B[l][j], complex.
    task automatic computeModel();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                longint sr;
                longint si;
                sr = 0;
                si = 0;
                for (int l = 0; l < 2; l++) begin
                    sr += a_r[2*i+l] * b_r[2*l+j] - a_i[2*i+l] * b_i[2*l+j];
                    si += a_r[2*i+l] * b_i[2*l+j] + a_i[2*i+l] * b_r[2*l+j];
                end
                e_r[2*i+j] = sr;
                e_i[2*i+j] = si;
            end
        end
    endtask

    function automatic longint randElem();
        return longint'($urandom_range(0, 65535)) - 64'sd32768;
    endfunction

    task automatic randomizeOperands();
        for (int e = 0; e < 4; e++) begin
            a_r[e] = randElem();
            a_i[e] = randElem();
            b_r[e] = randElem();
            b_i[e] = randElem();
        end
    endtask

    task automatic applyStimulus();
        for (int e = 0; e < 4; e++) begin
            a_re[e*W +: W] = a_r[e][W-1:0];
            a_im[e*W +: W] = a_i[e][W-1:0];
            b_re[e*W +: W] = b_r[e][W-1:0];
            b_im[e*W +: W] = b_i[e][W-1:0];
        end
        in_valid = 1'b1;
    endtask

    // Called at a negedge; returns #1 after the accepting edge.
    task automatic waitAccept(input string tag, output int accept_cyc);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput({tag, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
    endtask

    task automatic waitResult(input string tag);
        int lat;
        int busy_cnt;
        int ready_bad;
        @(negedge clk);
        lat = 0;
        busy_cnt = 0;
        ready_bad = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_cnt++;
            if (in_ready) ready_bad++;
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, 8);
        checkOutput({tag, "_busy_cycles"}, busy_cnt, 8);
        checkOutput({tag, "_in_ready_run"}, ready_bad, 0);
        checkOutput({tag, "_in_ready_done"}, in_ready, 0);
        checkOutput({tag, "_busy_done"}, busy, 0);
    endtask

    task automatic checkResult(input string tag);
        for (int e = 0; e < 4; e++) begin
            checkOutput($sformatf("%s_c%0d_re", tag, e), cRe(e), e_r[e]);
            checkOutput($sformatf("%s_c%0d_im", tag, e), cIm(e), e_i[e]);
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_out_valid_after"}, out_valid, 0);
        checkOutput({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    task automatic runTxn(input string tag);
        int acc;
        applyStimulus();
        waitAccept(tag, acc);
        computeModel();
        in_valid = 1'b0;
        // Scramble the port data after accept; the latched copy must be used.
        for (int e = 0; e < 4; e++) begin
            a_re[e*W +: W] = W'($urandom);
            b_im[e*W +: W] = W'($urandom);
        end
        waitResult(tag);
        checkResult(tag);
        consume(tag);
    endtask

    initial begin
        int acc;
        int prev_acc;
        int consume_cyc;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a_re = '0;
        a_im = '0;
        b_re = '0;
        b_im = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_c0_re", cRe(0), 0);
        checkOutput("reset_c3_im", cIm(3), 0);
        rst = 1'b0;
        @(negedge clk);

        // A=[[1+1j,2],[0,1j]], B=[[1j,1],[1,-1]]
        a_r = '{1, 2, 0, 0};  a_i = '{1, 0, 0, 1};
        b_r = '{0, 1, 1, -1}; b_i = '{1, 0, 0, 0};
        runTxn("small");

        a_r = '{1, 3, 0, -4}; a_i = '{2, -1, 0, 5};
        b_r = '{1, 0, 0, 1};  b_i = '{0, 0, 0, 0};
        runTxn("identity");

        for (int e = 0; e < 4; e++) begin
            a_r[e] = -32768; a_i[e] = -32768;
            b_r[e] = -32768; b_i[e] = -32768;
        end
        runTxn("maxneg");

        randomizeOperands();
        runTxn("rand0");

        // Backpressure: hold DONE while a new request waits on the inputs.
        randomizeOperands();
        applyStimulus();
        waitAccept("bp", acc);
        computeModel();
        randomizeOperands();
        applyStimulus();
        waitResult("bp");
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
            checkOutput($sformatf("bp_hold%0d_out_valid", k), out_valid, 1);
            checkOutput($sformatf("bp_hold%0d_busy", k), busy, 0);
            checkResult($sformatf("bp_hold%0d", k));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        consume_cyc = cyc;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_out_valid_after", out_valid, 0);
        checkOutput("bp_in_ready_after", in_ready, 1);
        waitAccept("bp_next", acc);
        checkOutput("bp_accept_gap", acc - consume_cyc, 1);
        computeModel();
        in_valid = 1'b0;
        waitResult("bp_next");
        checkResult("bp_next");
        consume("bp_next");

        // Reset in the middle of the run, with step 4 pending.
        randomizeOperands();
        applyStimulus();
        waitAccept("rst_mid", acc);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_in_ready", in_ready, 1);
        checkOutput("rst_mid_out_valid", out_valid, 0);
        checkOutput("rst_mid_busy", busy, 0);
        for (int e = 0; e < 4; e++) begin
            checkOutput($sformatf("rst_mid_c%0d_re", e), cRe(e), 0);
            checkOutput($sformatf("rst_mid_c%0d_im", e), cIm(e), 0);
        end
        randomizeOperands();
        runTxn("after_rst");

        // Back-to-back with both handshakes tied high.
        out_ready = 1'b1;
        randomizeOperands();
        applyStimulus();
        prev_acc = 0;
        for (int t = 0; t < 3; t++) begin
            waitAccept($sformatf("b2b%0d", t), acc);
            if (t > 0) checkOutput($sformatf("b2b%0d_spacing", t), acc - prev_acc, 10);
            prev_acc = acc;
            computeModel();
            randomizeOperands();
            applyStimulus();
            waitResult($sformatf("b2b%0d", t));
            checkResult($sformatf("b2b%0d", t));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
